pass_digit_loader: RTL and testbench
====================================

Name: pass_digit_loader

Overview:
- Upstream keypad/pushbutton front end for the ROM-based access controller.
- Synchronizes and debounces the raw "enter" pushbutton and the 4-bit digit switches.
- Issues exactly one single-cycle load pulse per clean press, with the sampled digit, driving the controller's digit input and load strobe.
- Counts the digits of one password entry, blocks presses beyond NUM_DIGITS until cleared, and provides entry progress for display.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required to accept a press or a release (sim value 4; board build 500000).
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- NUM_DIGITS, 4, digits per password entry; range 1..4.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- btn_raw  input  1  raw asynchronous pushbutton, 1 = pressed.
- sw_raw  input  4  raw asynchronous digit switches.
- clear  input  1  synchronous entry clear; tied to the controller's logout request.
- digit_out  output  4  digit captured at the last accepted press; feeds the controller's digit input.
- load_pulse  output  1  one-cycle strobe per accepted press; feeds the controller's load strobe.
- digit_idx  output  2  number of digits accepted so far in this entry, 0..NUM_DIGITS-1, saturating.
- entry_done  output  1  high once NUM_DIGITS digits are accepted; held until clear or rst.

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM in IDLE, counters 0, synchronizer flops 0. Reset mid-debounce or mid-entry abandons the partial entry. No load_pulse in the cycle rst deasserts.
- Synchronization:
  - btn_raw passes through a 2-flop synchronizer, giving btn_s.
  - sw_raw passes through a 2-flop synchronizer, giving sw_s.
  - All decisions use btn_s and sw_s only.
- FSM states: IDLE, DB_PRESS, FIRE, HELD, DB_RELEASE.
  - IDLE: btn_s=1 -> DB_PRESS, with cnt=1.
  - DB_PRESS: btn_s=0 -> IDLE, cnt=0 (bounce rejected). btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> FIRE. Otherwise cnt++.
  - FIRE (exactly one cycle):
    - If entry_done=0 and clear=0: load_pulse=1, digit_out<=sw_s, digit counter++.
    - Otherwise no pulse, digit_out unchanged.
    - Next state is always HELD.
  - HELD: btn_s=0 -> DB_RELEASE, with cnt=1.
  - DB_RELEASE: btn_s=1 -> HELD (release bounce). btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt++.
- Latency:
  - A clean press held from cycle 0 gives load_pulse registered high in cycle DEBOUNCE_CYCLES+2 (2 sync + DEBOUNCE_CYCLES debounce).
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles gives no pulse.
  - A button held indefinitely gives exactly one pulse.
- digit_out is registered and valid in the same cycle load_pulse is high. It holds its value until the next accepted press, or is cleared to 0 by clear/rst.
- Digit counter:
  - Internal 3-bit count 0..NUM_DIGITS.
  - entry_done = (count == NUM_DIGITS).
  - digit_idx = min(count, NUM_DIGITS-1), truncated to 2 bits.
  - The count never wraps: presses after entry_done are debounced normally but suppressed.
- clear (synchronous):
  - Next cycle: count=0, entry_done=0, digit_out=0.
  - The FSM is not reset, so a button still held must be released and re-pressed.
  - clear coincident with FIRE: clear wins, no load_pulse, count goes to 0.
- load_pulse is never high in two consecutive cycles.

Decomposition:
- Shared package: FSM state encodings (IDLE=0, DB_PRESS=1, FIRE=2, HELD=3, DB_RELEASE=4) and the default DEBOUNCE_CYCLES/CNT_W constants.
- One sub-module, sync2: a parameterized-width 2-flop synchronizer with async active-high reset. It is instantiated for btn_raw (width 1) and sw_raw (width 4).

Test Plan (DEBOUNCE_CYCLES=4, NUM_DIGITS=4):
- Reset, then btn_raw=1 from cycle 10 held 20 cycles, with sw_raw=4'h7 -> single load_pulse at cycle 16, digit_out=4'h7, digit_idx=1, entry_done=0.
- btn_raw bounce: high 2 cycles, low 1, high 2, then low -> no load_pulse; FSM returns to IDLE.
- Four clean presses with sw_raw=3,9,1,5 -> four pulses with digit_out 3,9,1,5 in order. entry_done=1 after the fourth; digit_idx stays 3.
- Fifth press after entry_done -> no load_pulse, digit_out stays 5. Then clear=1 for one cycle -> entry_done=0, digit_idx=0, digit_out=0. The next press with sw_raw=2 pulses digit_out=2.
- clear asserted in the exact FIRE cycle -> no pulse, count=0. Holding the button yields no further pulse until release plus re-press.
- rst=1 asynchronously mid-DB_PRESS (between clock edges) -> outputs 0 immediately. After release, a press held from deassertion pulses after DEBOUNCE_CYCLES+2 cycles.

Source files
------------

// File: rtl/pass_digit_loader_pkg.sv
// Shared definitions for the password digit loader: FSM encodings and default timing constants.
package pass_digit_loader_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    FIRE       = 3'd2,
    HELD       = 3'd3,
    DB_RELEASE = 3'd4
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_CNT_W           = 20;

endpackage

// File: rtl/pass_digit_loader_sync2.sv
// Two-flop synchronizer for asynchronous inputs, any width, cleared by async reset.
module sync2
  import pass_digit_loader_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops give the first stage a full cycle to settle out of metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pass_digit_loader.sv
// Keypad front end: synchronizes and debounces the enter button and digit switches,
// emits one load pulse per clean press and tracks progress through a password entry.
module pass_digit_loader
  import pass_digit_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int NUM_DIGITS      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic [3:0] sw_raw,
  input  logic       clear,
  output logic [3:0] digit_out,
  output logic       load_pulse,
  output logic [1:0] digit_idx,
  output logic       entry_done
);

  // Last count value of a debounce window; the counter starts at 1 on entry to a debounce state.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       COUNT_MAX = 3'(NUM_DIGITS);
  localparam logic [2:0]       IDX_MAX   = 3'(NUM_DIGITS - 1);

  logic             btn_s;
  logic [3:0]       sw_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       count;
  logic [2:0]       idx_sat;

  sync2 #(.WIDTH(1)) u_sync_btn (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_s)
  );

  sync2 #(.WIDTH(4)) u_sync_sw (
    .clk (clk),
    .rst (rst),
    .d   (sw_raw),
    .q   (sw_s)
  );

  assign entry_done = (count == COUNT_MAX);
  assign idx_sat    = (count >= IDX_MAX) ? IDX_MAX : count;
  assign digit_idx  = idx_sat[1:0];

  // Press/release debounce FSM with the load strobe, captured digit and digit count registered
  // alongside it; clear is applied last so it beats a coincident FIRE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      load_pulse <= 1'b0;
      digit_out  <= 4'h0;
      count      <= 3'd0;
    end else begin
      load_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= DB_PRESS;
            cnt   <= CNT_W'(1);
          end
        end
        DB_PRESS: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= FIRE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIRE: begin
          state <= HELD;
          if (!entry_done && !clear) begin
            load_pulse <= 1'b1;
            digit_out  <= sw_s;
            count      <= count + 3'd1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= DB_RELEASE;
            cnt   <= CNT_W'(1);
          end
        end
        DB_RELEASE: begin
          if (btn_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
      if (clear) begin
        count     <= 3'd0;
        digit_out <= 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_pass_digit_loader.sv
// Directed self-checking bench for pass_digit_loader (DEBOUNCE_CYCLES=4, NUM_DIGITS=4).
module tb_pass_digit_loader;

  localparam int DB  = 4;
  localparam int LAT = DB + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic [3:0] sw_raw;
  logic       clear;
  logic [3:0] digit_out;
  logic       load_pulse;
  logic [1:0] digit_idx;
  logic       entry_done;

  int checks = 0;
  int errors = 0;
  int pulses_total = 0;
  int back_to_back = 0;
  logic prev_pulse = 1'b0;

  int         np;
  int         lat;
  logic [3:0] seen;
  int         p0;

  pass_digit_loader #(.DEBOUNCE_CYCLES(DB), .CNT_W(20), .NUM_DIGITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .sw_raw     (sw_raw),
    .clear      (clear),
    .digit_out  (digit_out),
    .load_pulse (load_pulse),
    .digit_idx  (digit_idx),
    .entry_done (entry_done)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation and count it.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock cycles, sampling on the falling edge and tracking load pulses.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (load_pulse) begin
        pulses_total++;
        if (prev_pulse) back_to_back++;
      end
      prev_pulse = load_pulse;
    end
  endtask

  // Hold the button for 'hold' cycles with the given digit, then release and let it settle.
  // Latency counts edges after the first edge that samples the press.
  task automatic applyStimulus(input logic [3:0] dig, input int hold,
                               output int npulse, output int first_lat, output logic [3:0] dig_seen);
    int base;
    npulse    = 0;
    first_lat = -1;
    dig_seen  = 4'h0;
    sw_raw    = dig;
    btn_raw   = 1'b1;
    for (int i = 1; i <= hold + 12; i++) begin
      if (i == hold + 1) btn_raw = 1'b0;
      base = pulses_total;
      run(1);
      if (pulses_total != base) begin
        npulse++;
        if (first_lat < 0) first_lat = i - 1;
        dig_seen = digit_out;
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    btn_raw = 1'b0;
    sw_raw  = 4'h0;
    clear   = 1'b0;
    run(3);
    checkOutput("reset_digit_out", 32'(digit_out), 32'h0);
    checkOutput("reset_load_pulse", 32'(load_pulse), 32'h0);
    checkOutput("reset_digit_idx", 32'(digit_idx), 32'h0);
    checkOutput("reset_entry_done", 32'(entry_done), 32'h0);
    rst = 1'b0;
    run(3);

    $display("[TB] single clean press, digit 7");
    applyStimulus(4'h7, 20, np, lat, seen);
    checkOutput("p1_pulses", 32'(np), 32'd1);
    checkOutput("p1_latency", 32'(lat), 32'(LAT));
    checkOutput("p1_digit", 32'(seen), 32'h7);
    checkOutput("p1_digit_hold", 32'(digit_out), 32'h7);
    checkOutput("p1_idx", 32'(digit_idx), 32'd1);
    checkOutput("p1_done", 32'(entry_done), 32'd0);

    $display("[TB] bounce rejection");
    p0 = pulses_total;
    sw_raw  = 4'hA;
    btn_raw = 1'b1; run(2);
    btn_raw = 1'b0; run(1);
    btn_raw = 1'b1; run(2);
    btn_raw = 1'b0; run(12);
    checkOutput("bounce_pulses", 32'(pulses_total - p0), 32'd0);
    checkOutput("bounce_digit", 32'(digit_out), 32'h7);

    $display("[TB] clear then four digits");
    clear = 1'b1; run(1); clear = 1'b0;
    checkOutput("clr1_idx", 32'(digit_idx), 32'd0);
    checkOutput("clr1_digit", 32'(digit_out), 32'h0);
    begin
      logic [3:0] digs [4];
      digs[0] = 4'h3; digs[1] = 4'h9; digs[2] = 4'h1; digs[3] = 4'h5;
      for (int k = 0; k < 4; k++) begin
        applyStimulus(digs[k], 10, np, lat, seen);
        checkOutput($sformatf("seq%0d_pulses", k), 32'(np), 32'd1);
        checkOutput($sformatf("seq%0d_latency", k), 32'(lat), 32'(LAT));
        checkOutput($sformatf("seq%0d_digit", k), 32'(seen), 32'(digs[k]));
        checkOutput($sformatf("seq%0d_idx", k), 32'(digit_idx), (k + 1 >= 3) ? 32'd3 : 32'(k + 1));
        checkOutput($sformatf("seq%0d_done", k), 32'(entry_done), (k == 3) ? 32'd1 : 32'd0);
      end
    end

    $display("[TB] press after entry complete, then clear");
    applyStimulus(4'h8, 10, np, lat, seen);
    checkOutput("extra_pulses", 32'(np), 32'd0);
    checkOutput("extra_digit", 32'(digit_out), 32'h5);
    checkOutput("extra_idx", 32'(digit_idx), 32'd3);
    checkOutput("extra_done", 32'(entry_done), 32'd1);
    clear = 1'b1; run(1); clear = 1'b0;
    checkOutput("clr2_done", 32'(entry_done), 32'd0);
    checkOutput("clr2_idx", 32'(digit_idx), 32'd0);
    checkOutput("clr2_digit", 32'(digit_out), 32'h0);
    applyStimulus(4'h2, 10, np, lat, seen);
    checkOutput("after_clr_pulses", 32'(np), 32'd1);
    checkOutput("after_clr_digit", 32'(seen), 32'h2);
    checkOutput("after_clr_idx", 32'(digit_idx), 32'd1);

    $display("[TB] clear coincident with FIRE");
    p0 = pulses_total;
    sw_raw  = 4'hC;
    btn_raw = 1'b1;
    run(LAT);
    clear = 1'b1; run(1); clear = 1'b0;
    checkOutput("fireclr_pulse", 32'(load_pulse), 32'd0);
    checkOutput("fireclr_idx", 32'(digit_idx), 32'd0);
    checkOutput("fireclr_digit", 32'(digit_out), 32'h0);
    run(30);
    checkOutput("fireclr_held_pulses", 32'(pulses_total - p0), 32'd0);
    btn_raw = 1'b0; run(12);
    applyStimulus(4'h4, 10, np, lat, seen);
    checkOutput("repress_pulses", 32'(np), 32'd1);
    checkOutput("repress_latency", 32'(lat), 32'(LAT));
    checkOutput("repress_digit", 32'(seen), 32'h4);

    $display("[TB] async reset mid-debounce");
    sw_raw  = 4'h6;
    btn_raw = 1'b1;
    run(4);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_digit", 32'(digit_out), 32'h0);
    checkOutput("async_rst_idx", 32'(digit_idx), 32'd0);
    checkOutput("async_rst_pulse", 32'(load_pulse), 32'd0);
    @(negedge clk);
    btn_raw = 1'b0;
    run(3);
    rst = 1'b0;
    applyStimulus(4'h6, 10, np, lat, seen);
    checkOutput("post_rst_pulses", 32'(np), 32'd1);
    checkOutput("post_rst_latency", 32'(lat), 32'(LAT));
    checkOutput("post_rst_digit", 32'(seen), 32'h6);
    checkOutput("post_rst_idx", 32'(digit_idx), 32'd1);

    checkOutput("no_back_to_back", 32'(back_to_back), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
